// File: rtl/eth_parser_pkg.sv
// Shared types and helpers for the L2 stream parser: metadata record layout,
// TPID / EtherType constants and EtherType classification.
package eth_parser_pkg;

  localparam logic [15:0] TPID_8021Q  = 16'h8100;
  localparam logic [15:0] TPID_8021AD = 16'h88A8;
  localparam int unsigned ETH_BASE_HDR_BYTES = 14;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {StSof, StHdr, StBody} parse_state_e;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [2:0]  vlan_count;
    logic [11:0] outer_vid;
    logic [11:0] inner_vid;
    logic [15:0] ethertype;
    logic [5:0]  l2_len;
    logic [15:0] byte_count;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        is_unknown;
    logic        runt;
    logic        tag_overflow;
  } eth_meta_v2_t;

  typedef struct packed {
    logic is_ipv4;
    logic is_ipv6;
    logic is_arp;
    logic is_unknown;
  } eth_class_t;

  function automatic logic is_tpid(input logic [15:0] word);
    return (word == TPID_8021Q) || (word == TPID_8021AD);
  endfunction

  // One-hot class; anything not recognised lands in is_unknown.
  function automatic eth_class_t classify_ethertype(input logic [15:0] etype);
    eth_class_t c;
    c = '0;
    case (etype)
      ETYPE_IPV4: c.is_ipv4 = 1'b1;
      ETYPE_IPV6: c.is_ipv6 = 1'b1;
      ETYPE_ARP:  c.is_arp  = 1'b1;
      default:    c.is_unknown = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/meta_sync_fifo.sv
// Small synchronous FIFO for metadata records. Head is read straight from the
// register array, so it is stable until popped.
module meta_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage, pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eth_l2_stream_parser.sv
// AXI4-Stream L2 parser: one-stage registered pass-through plus per-frame header
// capture, VLAN/QinQ tag walk and a metadata record pushed into a small FIFO.
module eth_l2_stream_parser
  import eth_parser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned MAX_VLAN_TAGS = 2,
  parameter int unsigned META_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [$bits(eth_meta_v2_t)-1:0]  m_meta_tdata,
  output logic                             m_meta_tvalid,
  input  logic                             m_meta_tready
);

  localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
  localparam int unsigned HDR_BYTES = ETH_BASE_HDR_BYTES + 4 * MAX_VLAN_TAGS;
  localparam int unsigned IDX_W     = $clog2(HDR_BYTES);

  parse_state_e          r_state;
  logic [15:0]           r_byte_cnt;
  logic [7:0]            r_hdr [HDR_BYTES];
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_W-1:0]     r_m_tkeep;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;

  logic [7:0]            w_hdr_next [HDR_BYTES];
  logic [16:0]           w_keep_cnt;
  logic [16:0]           w_byte_sum;
  logic [15:0]           w_byte_cnt_next;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_meta_full;
  logic                  w_meta_empty;
  logic [IDX_W-1:0]      w_off;
  logic [2:0]            w_vlan_cnt;
  logic [11:0]           w_outer_vid;
  logic [11:0]           w_inner_vid;
  logic                  w_stop;
  logic [15:0]           w_etype;
  logic                  w_overflow;
  logic [5:0]            w_l2_len;
  logic                  w_runt;
  eth_class_t            w_cls;
  eth_meta_v2_t          w_meta;

  assign s_axis_tready = (~r_m_tvalid | m_axis_tready) & ~w_meta_full;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_push        = w_accept & s_axis_tlast;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_meta_tvalid = ~w_meta_empty;

  // Running frame byte count including this beat, saturating at 16 bits.
  always_comb begin
    w_keep_cnt = '0;
    for (int l = 0; l < KEEP_W; l++) w_keep_cnt = w_keep_cnt + 17'(s_axis_tkeep[l]);
    w_byte_sum      = {1'b0, r_byte_cnt} + w_keep_cnt;
    w_byte_cnt_next = w_byte_sum[16] ? 16'hFFFF : w_byte_sum[15:0];
  end

  // Header bytes as they will look after this beat; the first beat wipes stale bytes.
  always_comb begin
    for (int b = 0; b < HDR_BYTES; b++) w_hdr_next[b] = (r_state == StSof) ? 8'h00 : r_hdr[b];
    for (int l = 0; l < KEEP_W; l++) begin
      if (s_axis_tkeep[l] && ((32'(r_byte_cnt) + 32'(l)) < 32'(HDR_BYTES))) begin
        w_hdr_next[IDX_W'(32'(r_byte_cnt) + 32'(l))] = s_axis_tdata[8*l +: 8];
      end
    end
  end

  // Tag walk and record assembly over the captured header.
  always_comb begin
    w_off       = IDX_W'(12);
    w_vlan_cnt  = '0;
    w_outer_vid = '0;
    w_inner_vid = '0;
    w_stop      = 1'b0;
    for (int t = 0; t < MAX_VLAN_TAGS; t++) begin
      if (!w_stop && is_tpid({w_hdr_next[w_off], w_hdr_next[w_off + IDX_W'(1)]})) begin
        if (t == 0) w_outer_vid = {w_hdr_next[w_off + IDX_W'(2)][3:0], w_hdr_next[w_off + IDX_W'(3)]};
        if (t == 1) w_inner_vid = {w_hdr_next[w_off + IDX_W'(2)][3:0], w_hdr_next[w_off + IDX_W'(3)]};
        w_vlan_cnt = w_vlan_cnt + 3'd1;
        w_off      = w_off + IDX_W'(4);
      end else begin
        w_stop = 1'b1;
      end
    end
    w_etype    = {w_hdr_next[w_off], w_hdr_next[w_off + IDX_W'(1)]};
    w_overflow = is_tpid(w_etype);
    w_l2_len   = 6'(w_off) + 6'd2;
    // A leftover TPID means the real EtherType was never reached.
    w_cls      = classify_ethertype(w_overflow ? 16'h0000 : w_etype);
    w_runt     = w_byte_cnt_next < {10'h000, w_l2_len};

    w_meta.dest_mac     = {w_hdr_next[0], w_hdr_next[1], w_hdr_next[2],
                           w_hdr_next[3], w_hdr_next[4], w_hdr_next[5]};
    w_meta.src_mac      = {w_hdr_next[6], w_hdr_next[7], w_hdr_next[8],
                           w_hdr_next[9], w_hdr_next[10], w_hdr_next[11]};
    w_meta.vlan_count   = w_vlan_cnt;
    w_meta.outer_vid    = w_outer_vid;
    w_meta.inner_vid    = w_inner_vid;
    w_meta.ethertype    = w_etype;
    w_meta.l2_len       = w_l2_len;
    w_meta.byte_count   = w_byte_cnt_next;
    w_meta.is_ipv4      = w_cls.is_ipv4 & ~w_runt;
    w_meta.is_ipv6      = w_cls.is_ipv6 & ~w_runt;
    w_meta.is_arp       = w_cls.is_arp & ~w_runt;
    w_meta.is_unknown   = w_cls.is_unknown | w_runt;
    w_meta.runt         = w_runt;
    w_meta.tag_overflow = w_overflow;
  end

  // Frame FSM: tlast always returns to SOF, header phase ends once fully captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StSof;
    end else if (w_accept) begin
      if (s_axis_tlast) begin
        r_state <= StSof;
      end else begin
        unique case (r_state)
          StSof:   r_state <= StHdr;
          StHdr:   if (w_byte_cnt_next >= 16'(HDR_BYTES)) r_state <= StBody;
          StBody:  r_state <= StBody;
          default: r_state <= StSof;
        endcase
      end
    end
  end

  // Header capture and byte counter; the counter restarts at each frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      for (int b = 0; b < HDR_BYTES; b++) r_hdr[b] <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= s_axis_tlast ? 16'h0000 : w_byte_cnt_next;
      for (int b = 0; b < HDR_BYTES; b++) r_hdr[b] <= w_hdr_next[b];
    end
  end

  // Egress register stage: load on accept, hold while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= s_axis_tdata;
      r_m_tkeep  <= s_axis_tkeep;
      r_m_tlast  <= s_axis_tlast;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  meta_sync_fifo #(
    .WIDTH ($bits(eth_meta_v2_t)),
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_meta),
    .i_pop   (m_meta_tready),
    .o_rdata (m_meta_tdata),
    .o_full  (w_meta_full),
    .o_empty (w_meta_empty)
  );

endmodule

// File: tb/tb_eth_l2_stream_parser.sv
// Directed bench for eth_l2_stream_parser: 64-bit main instance plus a 128-bit
// instance for the single-beat runt case.
module tb_eth_l2_stream_parser;
  import eth_parser_pkg::*;

  localparam int unsigned MW = $bits(eth_meta_v2_t);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [MW-1:0] meta_tdata;
  logic          meta_tvalid, meta_tready;

  logic [127:0]  w_tdata;
  logic [15:0]   w_tkeep;
  logic          w_tvalid, w_tready, w_tlast;
  logic [127:0]  wm_tdata;
  logic [15:0]   wm_tkeep;
  logic          wm_tvalid, wm_tlast;
  logic [MW-1:0] wmeta_tdata;
  logic          wmeta_tvalid;
  logic          w_one = 1'b1;

  int            n_cmp, n_err;
  logic [7:0]    fb [128];
  eth_meta_v2_t  meta_q [$];
  logic [63:0]   in_q [$];
  logic [63:0]   eg_q [$];
  eth_meta_v2_t  m, head;

  always #5 clk = ~clk;

  eth_l2_stream_parser #(.DATA_WIDTH(64), .MAX_VLAN_TAGS(2), .META_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_meta_tdata(meta_tdata), .m_meta_tvalid(meta_tvalid), .m_meta_tready(meta_tready)
  );

  eth_l2_stream_parser #(.DATA_WIDTH(128), .MAX_VLAN_TAGS(2), .META_DEPTH(4)) u_w (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(w_tdata), .s_axis_tkeep(w_tkeep), .s_axis_tvalid(w_tvalid),
    .s_axis_tready(w_tready), .s_axis_tlast(w_tlast),
    .m_axis_tdata(wm_tdata), .m_axis_tkeep(wm_tkeep), .m_axis_tvalid(wm_tvalid),
    .m_axis_tready(w_one), .m_axis_tlast(wm_tlast),
    .m_meta_tdata(wmeta_tdata), .m_meta_tvalid(wmeta_tvalid), .m_meta_tready(w_one)
  );

  // Record every metadata and egress handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && meta_tvalid && meta_tready) meta_q.push_back(meta_tdata);
    if (rst_n && m_tvalid && m_tready) eg_q.push_back(m_tdata);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic last,
                            input bit chk);
    int g = 0;
    s_tdata = d; s_tkeep = k; s_tlast = last; s_tvalid = 1'b1;
    while (!s_tready && g < 300) begin
      @(posedge clk); #1; g++;
    end
    check("ingress_ready", s_tready, 1);
    if (s_tready) begin
      @(posedge clk);
      in_q.push_back(d);
      #1;
      if (chk) begin
        check("egress_valid", m_tvalid, 1);
        check("egress_data", m_tdata, d);
        check("egress_last", m_tlast, last);
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit chk);
    int nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      d = '0; k = '0;
      for (int l = 0; l < 8; l++) begin
        if (b * 8 + l < len) begin
          d[8*l +: 8] = fb[b*8+l];
          k[l] = 1'b1;
        end
      end
      drive_beat(d, k, (b == nb - 1), chk);
    end
  endtask

  task automatic get_meta(output eth_meta_v2_t r);
    int g = 0;
    while (meta_q.size() == 0 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check("meta_arrived", (meta_q.size() > 0), 1);
    if (meta_q.size() > 0) r = meta_q.pop_front();
    else r = '0;
  endtask

  task automatic base_frame(input logic [7:0] et_hi, input logic [7:0] et_lo);
    for (int i = 0; i < 128; i++) fb[i] = 8'(i);
    fb[0] = 8'h00; fb[1] = 8'h11; fb[2]  = 8'h22; fb[3]  = 8'h33; fb[4]  = 8'h44; fb[5]  = 8'h55;
    fb[6] = 8'h66; fb[7] = 8'h77; fb[8]  = 8'h88; fb[9]  = 8'h99; fb[10] = 8'hAA; fb[11] = 8'hBB;
    fb[12] = et_hi; fb[13] = et_lo;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; meta_tready = 1'b1;
    w_tdata = '0; w_tkeep = '0; w_tvalid = 1'b0; w_tlast = 1'b0;
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_meta_tvalid", meta_tvalid, 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tready", s_tready, 1);
    check("post_rst_m_tdata", m_tdata, 0);
    check("post_rst_meta_tvalid", meta_tvalid, 0);

    // Untagged IPv4, 64 bytes, egress compared beat by beat.
    base_frame(8'h08, 8'h00);
    send_frame(64, 1);
    get_meta(m);
    check("t1_vlan_count", m.vlan_count, 0);
    check("t1_ethertype", m.ethertype, 16'h0800);
    check("t1_l2_len", m.l2_len, 14);
    check("t1_byte_count", m.byte_count, 64);
    check("t1_is_ipv4", m.is_ipv4, 1);
    check("t1_is_unknown", m.is_unknown, 0);
    check("t1_dest_mac", m.dest_mac, 48'h0011_2233_4455);
    check("t1_src_mac", m.src_mac, 48'h6677_8899_AABB);
    check("t1_runt", m.runt, 0);

    // QinQ: 88A8/0x123 then 8100/0x456, IPv6, 80 bytes.
    base_frame(8'h88, 8'hA8);
    fb[14] = 8'h01; fb[15] = 8'h23; fb[16] = 8'h81; fb[17] = 8'h00;
    fb[18] = 8'h04; fb[19] = 8'h56; fb[20] = 8'h86; fb[21] = 8'hDD;
    send_frame(80, 0);
    get_meta(m);
    check("t2_vlan_count", m.vlan_count, 2);
    check("t2_outer_vid", m.outer_vid, 12'h123);
    check("t2_inner_vid", m.inner_vid, 12'h456);
    check("t2_ethertype", m.ethertype, 16'h86DD);
    check("t2_l2_len", m.l2_len, 22);
    check("t2_is_ipv6", m.is_ipv6, 1);
    check("t2_byte_count", m.byte_count, 80);
    check("t2_overflow", m.tag_overflow, 0);

    // Three stacked 8100 tags against a limit of two.
    base_frame(8'h81, 8'h00);
    fb[14] = 8'h00; fb[15] = 8'h0A; fb[16] = 8'h81; fb[17] = 8'h00;
    fb[18] = 8'h00; fb[19] = 8'h0B; fb[20] = 8'h81; fb[21] = 8'h00;
    fb[22] = 8'h00; fb[23] = 8'h0C; fb[24] = 8'h08; fb[25] = 8'h00;
    send_frame(64, 0);
    get_meta(m);
    check("t3_vlan_count", m.vlan_count, 2);
    check("t3_outer_vid", m.outer_vid, 12'h00A);
    check("t3_inner_vid", m.inner_vid, 12'h00B);
    check("t3_overflow", m.tag_overflow, 1);
    check("t3_is_unknown", m.is_unknown, 1);
    check("t3_is_ipv4", m.is_ipv4, 0);
    check("t3_l2_len", m.l2_len, 22);

    // Single-beat 10-byte runt on the 128-bit instance.
    for (int l = 0; l < 10; l++) w_tdata[8*l +: 8] = 8'hA0 + 8'(l);
    w_tkeep = 16'h03FF; w_tlast = 1'b1; w_tvalid = 1'b1;
    check("t4_tready", w_tready, 1);
    @(posedge clk); #1;
    w_tvalid = 1'b0;
    check("t4_meta_tvalid", wmeta_tvalid, 1);
    m = wmeta_tdata;
    check("t4_runt", m.runt, 1);
    check("t4_is_unknown", m.is_unknown, 1);
    check("t4_is_ipv4", m.is_ipv4, 0);
    check("t4_byte_count", m.byte_count, 10);
    check("t4_l2_len", m.l2_len, 14);
    check("t4_fsm_sof", (u_w.r_state == StSof), 1);
    check("t4_egress_last", wm_tlast, 1);

    // Metadata backpressure: four records fill the FIFO, the fifth frame stalls.
    repeat (2) @(posedge clk);
    #1;
    in_q.delete(); eg_q.delete();
    base_frame(8'h08, 8'h00);
    meta_tready = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(16 + f, 0);
    check("t5_ready_drop", s_tready, 0);
    check("t5_meta_tvalid", meta_tvalid, 1);
    fork
      send_frame(20, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("t5_still_stalled", s_tready, 0);
        head = meta_tdata;
        check("t5_head_hold", head.byte_count, 16);
        meta_tready = 1'b1;
      end
    join
    for (int f = 0; f < 5; f++) begin
      get_meta(m);
      check("t5_order_byte_count", m.byte_count, 64'(16 + f));
    end
    repeat (5) @(posedge clk);
    #1;
    check("t5_beat_count", eg_q.size(), in_q.size());
    check("t5_beat_total", in_q.size(), 14);
    for (int i = 0; i < in_q.size() && i < eg_q.size(); i++) check("t5_beat_data", eg_q[i], in_q[i]);

    // Reset in the middle of frame A's header, then frame B alone.
    base_frame(8'h08, 8'h00);
    drive_beat({fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1], fb[0]}, 8'hFF, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_m_tvalid", m_tvalid, 0);
    check("t6_rst_m_tdata", m_tdata, 0);
    check("t6_rst_meta_tvalid", meta_tvalid, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_tready", s_tready, 1);
    base_frame(8'h08, 8'h06);
    send_frame(60, 0);
    get_meta(m);
    check("t6_byte_count", m.byte_count, 60);
    check("t6_is_arp", m.is_arp, 1);
    check("t6_ethertype", m.ethertype, 16'h0806);
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_extra_meta", meta_q.size(), 0);
    check("t6_meta_idle", meta_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
